// File: rtl/dram_arbiter.sv
// rtl/dram_arbiter.sv - two-requester arbiter for the shared data DRAM
//
// Requester 0 is the core LSU and requester 1 is the debug/DMA side. One
// operation (read or write) is granted per cycle. The chosen request drives the
// DRAM ports combinationally in the accept cycle. Read data returns to the
// issuing requester one cycle later.
//
// Optional feature macro: DRAM_ARB_RR_EN
//   undefined : fixed priority m0 > m1, with a MAX_BURST starvation guard
//   defined   : round-robin between the two requesters under contention
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   mX_req_valid/ready  request handshake (X = 0, 1); ready is combinational
//   mX_req_we/addr/wdata request payload, held stable until ready
//   mX_rsp_valid/rdata  read response, exactly one cycle after accept
//   dram_rd_en/addr     DRAM read port (data registered, back next cycle)
//   dram_rd_data        DRAM registered read data
//   dram_wr_en/addr/data DRAM write port (committed on the falling edge)
//   arb_busy            status: response outstanding or any request valid

module dram_arbiter #(
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req_valid,
    output logic              m0_req_ready,
    input  logic              m0_req_we,
    input  logic [ADDR_W-1:0] m0_req_addr,
    input  logic [DATA_W-1:0] m0_req_wdata,
    output logic              m0_rsp_valid,
    output logic [DATA_W-1:0] m0_rsp_rdata,
    input  logic              m1_req_valid,
    output logic              m1_req_ready,
    input  logic              m1_req_we,
    input  logic [ADDR_W-1:0] m1_req_addr,
    input  logic [DATA_W-1:0] m1_req_wdata,
    output logic              m1_rsp_valid,
    output logic [DATA_W-1:0] m1_rsp_rdata,
    output logic              dram_rd_en,
    output logic [ADDR_W-1:0] dram_rd_addr,
    input  logic [DATA_W-1:0] dram_rd_data,
    output logic              dram_wr_en,
    output logic [ADDR_W-1:0] dram_wr_addr,
    output logic [DATA_W-1:0] dram_wr_data,
    output logic              arb_busy
);

    logic       last_grant;
    logic [3:0] burst_cnt;
    logic       rsp_pend;
    logic       rsp_id;

    logic              gnt0;
    logic              gnt1;
    logic              gnt_any;
    logic              gnt_we;
    logic [ADDR_W-1:0] gnt_addr;
    logic [DATA_W-1:0] gnt_wdata;

`ifndef DRAM_ARB_RR_EN
    // The owner is masked once it has used up its burst while the other side
    // waits. The >= comparison lets a counter that grew during uncontended
    // streaming still yield at once when contention begins.
    logic burst_limit;
    logic mask0;
    logic mask1;

    assign burst_limit = (burst_cnt >= 4'(MAX_BURST));
    assign mask0       = burst_limit && (last_grant == 1'b0) && m1_req_valid;
    assign mask1       = burst_limit && (last_grant == 1'b1) && m0_req_valid;
`endif

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst) begin
`ifdef DRAM_ARB_RR_EN
            if (m0_req_valid && m1_req_valid) begin
                gnt0 = last_grant;
                gnt1 = !last_grant;
            end else begin
                gnt0 = m0_req_valid;
                gnt1 = m1_req_valid;
            end
`else
            if (m0_req_valid && !mask0) begin
                gnt0 = 1'b1;
            end else if (m1_req_valid && !mask1) begin
                gnt1 = 1'b1;
            end
`endif
        end
    end

    assign gnt_any   = gnt0 || gnt1;
    assign gnt_we    = gnt1 ? m1_req_we    : m0_req_we;
    assign gnt_addr  = gnt1 ? m1_req_addr  : m0_req_addr;
    assign gnt_wdata = gnt1 ? m1_req_wdata : m0_req_wdata;

    assign m0_req_ready = gnt0;
    assign m1_req_ready = gnt1;

    always_comb begin
        dram_rd_en   = 1'b0;
        dram_rd_addr = '0;
        dram_wr_en   = 1'b0;
        dram_wr_addr = '0;
        dram_wr_data = '0;
        if (gnt_any) begin
            if (gnt_we) begin
                dram_wr_en   = 1'b1;
                dram_wr_addr = gnt_addr;
                dram_wr_data = gnt_wdata;
            end else begin
                dram_rd_en   = 1'b1;
                dram_rd_addr = gnt_addr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
            burst_cnt  <= 4'd0;
            rsp_pend   <= 1'b0;
            rsp_id     <= 1'b0;
        end else begin
            rsp_pend <= gnt_any && !gnt_we;
            rsp_id   <= gnt1;
            if (gnt_any) begin
                last_grant <= gnt1;
                // A zero count means no grant since reset, so treat it as a switch.
                if ((gnt1 == last_grant) && (burst_cnt != 4'd0)) begin
                    if (burst_cnt != 4'd15) begin
                        burst_cnt <= burst_cnt + 4'd1;
                    end
                end else begin
                    burst_cnt <= 4'd1;
                end
            end
        end
    end

    // Gating with rst drops a response whose read was accepted just before reset.
    assign m0_rsp_valid = rsp_pend && !rst && (rsp_id == 1'b0);
    assign m1_rsp_valid = rsp_pend && !rst && (rsp_id == 1'b1);
    assign m0_rsp_rdata = m0_rsp_valid ? dram_rd_data : '0;
    assign m1_rsp_rdata = m1_rsp_valid ? dram_rd_data : '0;

    assign arb_busy = !rst && (rsp_pend || m0_req_valid || m1_req_valid);

endmodule

// File: tb/tb_dram_arbiter.sv
// tb/tb_dram_arbiter.sv - self-checking bench for dram_arbiter with a DRAM model and response scoreboard

module tb_dram_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m0_req_valid = 1'b0, m0_req_we = 1'b0;
    logic [11:0] m0_req_addr = '0;
    logic [31:0] m0_req_wdata = '0;
    logic        m1_req_valid = 1'b0, m1_req_we = 1'b0;
    logic [11:0] m1_req_addr = '0;
    logic [31:0] m1_req_wdata = '0;
    logic        m0_req_ready, m1_req_ready, m0_rsp_valid, m1_rsp_valid;
    logic [31:0] m0_rsp_rdata, m1_rsp_rdata;
    logic        dram_rd_en, dram_wr_en, arb_busy;
    logic [11:0] dram_rd_addr, dram_wr_addr;
    logic [31:0] dram_wr_data;
    logic [31:0] dram_rd_data = '0;

    dram_arbiter #(.ADDR_W(12), .DATA_W(32), .MAX_BURST(4)) dut (
        .clk(clk), .rst(rst),
        .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_req_we(m0_req_we),
        .m0_req_addr(m0_req_addr), .m0_req_wdata(m0_req_wdata),
        .m0_rsp_valid(m0_rsp_valid), .m0_rsp_rdata(m0_rsp_rdata),
        .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_req_we(m1_req_we),
        .m1_req_addr(m1_req_addr), .m1_req_wdata(m1_req_wdata),
        .m1_rsp_valid(m1_rsp_valid), .m1_rsp_rdata(m1_rsp_rdata),
        .dram_rd_en(dram_rd_en), .dram_rd_addr(dram_rd_addr), .dram_rd_data(dram_rd_data),
        .dram_wr_en(dram_wr_en), .dram_wr_addr(dram_wr_addr), .dram_wr_data(dram_wr_data),
        .arb_busy(arb_busy)
    );

    always #5 clk = ~clk;

    // DRAM model: write on the falling edge, registered read on the rising edge.
    logic [31:0] mem [4096];
    logic [31:0] ref_mem [4096];
    always @(negedge clk) if (dram_wr_en) mem[dram_wr_addr] <= dram_wr_data;
    always @(posedge clk) if (dram_rd_en) dram_rd_data <= mem[dram_rd_addr];

    typedef struct {
        logic        id;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;
    int rsp0_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Monitor: strict one-cycle response latency against the scoreboard, then
    // record this cycle's accepted request against the reference memory.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            check("rst_outputs", {m0_req_ready, m1_req_ready, dram_rd_en, dram_wr_en,
                                  m0_rsp_valid, m1_rsp_valid, arb_busy}, 0);
            check("rst_rdata", m0_rsp_rdata | m1_rsp_rdata, 0);
            sb.delete();
        end else begin
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("rsp_valid", {m1_rsp_valid, m0_rsp_valid}, e.id ? 2'b10 : 2'b01);
                check("rsp_rdata", e.id ? m1_rsp_rdata : m0_rsp_rdata, e.data);
                check("rsp_other_rdata", e.id ? m0_rsp_rdata : m1_rsp_rdata, 0);
            end else begin
                check("no_rsp", {m1_rsp_valid, m0_rsp_valid}, 0);
            end
            if (m0_rsp_valid) rsp0_cnt++;
            check("one_ready", m0_req_ready & m1_req_ready, 0);
            if ((m0_req_valid && m0_req_ready) || (m1_req_valid && m1_req_ready)) begin
                logic        id;
                logic        we;
                logic [11:0] a;
                logic [31:0] d;
                id = m1_req_ready;
                we = id ? m1_req_we : m0_req_we;
                a  = id ? m1_req_addr : m0_req_addr;
                d  = id ? m1_req_wdata : m0_req_wdata;
                if (we) begin
                    check("wr_issue", {dram_wr_en, dram_rd_en, 4'h0, dram_wr_addr}, {2'b10, 4'h0, a});
                    check("wr_data", dram_wr_data, d);
                    ref_mem[a] = d;
                end else begin
                    check("rd_issue", {dram_rd_en, dram_wr_en, 4'h0, dram_rd_addr}, {2'b10, 4'h0, a});
                    sb.push_back('{id: id, data: ref_mem[a]});
                end
            end else begin
                check("idle_enables", {dram_rd_en, dram_wr_en}, 0);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_req(input bit id, input bit we, input logic [11:0] a, input logic [31:0] d);
        bit ok;
        ok = 1'b0;
        if (!id) begin
            m0_req_valid = 1'b1; m0_req_we = we; m0_req_addr = a; m0_req_wdata = d;
        end else begin
            m1_req_valid = 1'b1; m1_req_we = we; m1_req_addr = a; m1_req_wdata = d;
        end
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            ok = id ? m1_req_ready : m0_req_ready;
            @(posedge clk);
            #1;
        end
        check("req_accept", ok, 1);
        if (!id) m0_req_valid = 1'b0; else m1_req_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int g0;
        int g1;
        int base;
        for (int i = 0; i < 4096; i++) begin
            mem[i]     = 32'(i);
            ref_mem[i] = 32'(i);
        end

        // Reset with requests pending: nothing may be granted and busy stays low.
        m0_req_valid = 1'b1;
        m1_req_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        m0_req_valid = 1'b0;
        m1_req_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("idle_busy", arb_busy, 0);
        @(posedge clk);
        #1;

        // Write then immediate read of the same word returns the new data.
        do_req(0, 1, 12'h010, 32'hDEADBEEF);
        do_req(0, 0, 12'h010, 32'h0);
        @(negedge clk);
        check("busy_rsp_pending", arb_busy, 1);
        check("raw_m0_rsp", m0_rsp_rdata, 32'hDEADBEEF);
        @(posedge clk);
        #1;
        idle(2);

        // Eight back-to-back reads, one response per cycle.
        base = rsp0_cnt;
        for (int i = 0; i < 8; i++) do_req(0, 0, 12'(i), 32'h0);
        idle(3);
        check("stream_rsp_count", rsp0_cnt - base, 8);

        // Contention from a clean reset state.
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        m0_req_valid = 1'b1; m0_req_we = 1'b0; m0_req_addr = 12'h100;
        m1_req_valid = 1'b1; m1_req_we = 1'b0; m1_req_addr = 12'h200;
        g0 = 0;
        g1 = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
`ifdef DRAM_ARB_RR_EN
            check("rr_grant_m0", m0_req_ready, (c % 2) == 0);
`else
            check("fixed_grant_m0", m0_req_ready, (c % 5) != 4);
`endif
            g0 += int'(m0_req_ready);
            g1 += int'(m1_req_ready);
            @(posedge clk);
            #1;
        end
        m0_req_valid = 1'b0;
        m1_req_valid = 1'b0;
`ifdef DRAM_ARB_RR_EN
        check("grants_m0", g0, 10);
        check("grants_m1", g1, 10);
`else
        check("grants_m0", g0, 16);
        check("grants_m1", g1, 4);
`endif
        idle(2);

        // m1 read accepted, then reset: the response is dropped.
        do_req(1, 0, 12'h123, 32'h0);
        rst = 1'b1;
        m0_req_valid = 1'b1; m0_req_we = 1'b0; m0_req_addr = 12'h000;
        m1_req_valid = 1'b1; m1_req_we = 1'b1; m1_req_addr = 12'h001;
        @(negedge clk);
        check("rst_drop_m1_rsp", m1_rsp_valid, 0);
        check("rst_enables", {dram_rd_en, dram_wr_en}, 0);
        @(posedge clk);
        #1;
        m1_req_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_grant", m0_req_ready, 1);
        @(posedge clk);
        #1;
        m0_req_valid = 1'b0;
        idle(2);

        // Simultaneous m0 write and m1 read of the same word.
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        m0_req_valid = 1'b1; m0_req_we = 1'b1; m0_req_addr = 12'h055; m0_req_wdata = 32'h1;
        m1_req_valid = 1'b1; m1_req_we = 1'b0; m1_req_addr = 12'h055;
        @(negedge clk);
        check("both_first_grant", {m1_req_ready, m0_req_ready}, 2'b01);
        @(posedge clk);
        #1;
        m0_req_valid = 1'b0;
        @(negedge clk);
        check("both_second_grant", {m1_req_ready, m0_req_ready}, 2'b10);
        @(posedge clk);
        #1;
        m1_req_valid = 1'b0;
        @(negedge clk);
        check("both_m1_rdata", m1_rsp_rdata, 32'h1);
        @(posedge clk);
        #1;
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dram_arbiter.md
Name: dram_arbiter

Overview:
- Two-requester arbiter sharing the single data DRAM (one read port with 1-cycle registered read data, one write port committed on the falling clock edge).
- Requester 0 is the core LSU; requester 1 is the debug/DMA side.
- Grants one operation (read or write) per cycle, drives the DRAM control signals, and routes read data back to the issuing requester with a 1-cycle response.

Parameters:
- ADDR_W, 12, DRAM word-address width (4K-word depth).
- DATA_W, 32, data word width.
- MAX_BURST, 4, max consecutive grants to one requester while the other waits (range 1..15).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous active-high reset.
- m0_req_valid  in  1  requester 0 request valid.
- m0_req_ready  out  1  requester 0 request accepted this cycle.
- m0_req_we  in  1  1 = write, 0 = read.
- m0_req_addr  in  ADDR_W  word address.
- m0_req_wdata  in  DATA_W  write data.
- m0_rsp_valid  out  1  read data valid for requester 0.
- m0_rsp_rdata  out  DATA_W  read data.
- m1_req_valid, m1_req_ready, m1_req_we, m1_req_addr, m1_req_wdata, m1_rsp_valid, m1_rsp_rdata: same as m0_*, for requester 1.
- dram_rd_en  out  1  DRAM read enable.
- dram_rd_addr  out  ADDR_W  DRAM read address.
- dram_rd_data  in  DATA_W  DRAM registered read data.
- dram_wr_en  out  1  DRAM write enable.
- dram_wr_addr  out  ADDR_W  DRAM write address.
- dram_wr_data  out  DATA_W  DRAM write data.
- arb_busy  out  1  any response outstanding or any request valid (status only).

Behaviour:
- Handshake:
  - A request transfers when valid && ready at a posedge.
  - Requester holds valid/we/addr/wdata stable until ready.
  - ready is combinational from the valids and arbitration state; at most one ready is high per cycle.
- Issue (combinational in the accept cycle T):
  - Read: dram_rd_en=1 with rd_addr=req_addr.
  - Write: dram_wr_en=1 with wr_addr and wr_data; data is written at the falling edge of cycle T.
  - Enables are 0 when nothing is granted. Addresses and data default to 0 when the corresponding enable is 0.
- Response:
  - A read accepted in cycle T gives mX_rsp_valid=1 for exactly cycle T+1, with mX_rsp_rdata=dram_rd_data.
  - Writes produce no response.
  - Responses cannot be back-pressured.
  - rsp_rdata for a non-selected requester is 0.
  - Response tag registers: rsp_pend (1b) and rsp_id (1b).
- Ordering:
  - A read in T+1 to an address written in T returns the new data; no extra stall is needed.
  - Back-to-back reads every cycle give full throughput.
- Arbitration state:
  - last_grant (1b) and burst_cnt (4b).
  - burst_cnt increments on each consecutive grant to the same requester and resets to 1 on a grant switch.
  - When burst_cnt == MAX_BURST and the other requester is valid, the current owner is masked for one cycle.
- Priority (macro absent): fixed; m0 wins whenever valid unless masked by the burst limit.
- Reset:
  - rst high forces both ready=0, dram_rd_en=0, dram_wr_en=0, rsp_valid=0, rsp_rdata=0, last_grant=1 (so m0 is preferred first), burst_cnt=0, arb_busy=0.
  - A read accepted in the cycle before rst asserts returns no response.
- Boundary cases:
  - Address wrap is not applicable; addresses are passed through unmodified.
  - Both valid with one already burst-limited: the other requester wins.
  - One valid, other idle: no burst limit applies, so there is unlimited streaming.

Optional Feature:
- Macro: DRAM_ARB_RR_EN.
- Defined: round-robin arbitration. When both requesters are valid, the grant goes to the requester not equal to last_grant. The burst counter is still maintained but never masks, since requesters alternate every cycle under contention.
- Undefined: fixed priority m0 > m1 with the MAX_BURST starvation guard described above.

Test Plan:
- m0 write addr 0x010 data 0xDEADBEEF in cycle T, m0 read 0x010 in T+1 -> m0_rsp_valid in T+2 with rdata 0xDEADBEEF; m1_rsp_valid stays 0.
- m0 issues 8 back-to-back reads 0x000..0x007 preloaded with value = addr -> 8 consecutive rsp_valid cycles returning 0..7 in order.
- Fixed priority, MAX_BURST=4, both valid continuously:
  - m0 granted 4 cycles, then m1 granted 1, then m0 granted 4, and so on.
  - Count grants over 20 cycles: m0=16, m1=4.
- DRAM_ARB_RR_EN defined, both valid continuously -> grants alternate m0, m1, m0, ...; first grant goes to m0 after reset.
- m1 read 0x123 accepted in cycle T, rst asserted in T+1 -> no m1_rsp_valid; all DRAM enables 0 while rst is high; a normal grant occurs the first cycle after rst deasserts.
- m0 write 0x055 = 0x1 and m1 read 0x055 both valid in the same cycle -> m0 write granted first, m1 read granted the next cycle and returns 0x1.
